// File: rtl/wb_trace_streamer.sv
// Writeback trace port: buffers retiring {rd, data} results in a small FIFO
// and streams each one as a byte-framed packet over an 8-bit valid/ack bus.
module wb_trace_streamer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4,
    parameter int TAG_EN     = 1,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wb_ready,
    output logic [7:0]               out_byte,
    output logic                     out_strobe,
    output logic                     out_sof,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int NDB = DATA_W / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int KW  = $clog2(NDB) + 1;
    localparam int EW  = 5 + DATA_W;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [4:0]        frm_rd_q, frm_rd_d;
    logic [DATA_W-1:0] frm_data_q, frm_data_d;
    logic [KW-1:0]     k_q, k_d;

    logic              push, pop, xfer, last;
    logic [KW-1:0]     byte_idx;
    logic [DATA_W-1:0] data_shift;

    assign wb_ready   = (level_q != LW'(DEPTH));
    assign push       = wb_valid & wb_ready;
    assign xfer       = out_strobe & out_ack;
    assign last       = (state_q == DATA) && (k_q == KW'(NDB - 1));
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

    // Output byte mux: everything is decoded from registered frame state, so
    // byte and sof are naturally held while the consumer stalls.
    always_comb begin
        byte_idx   = (BIG_ENDIAN != 0) ? (KW'(NDB - 1) - k_q) : k_q;
        data_shift = frm_data_q >> {byte_idx, 3'b000};
        out_strobe = (state_q != IDLE);
        out_byte   = 8'h00;
        out_sof    = 1'b0;
        case (state_q)
            HDR: begin
                out_byte = {3'b101, frm_rd_q};
                out_sof  = 1'b1;
            end
            DATA: begin
                out_byte = data_shift[7:0];
                out_sof  = (TAG_EN == 0) && (k_q == '0);
            end
            default: ;
        endcase
    end

    // Framer next state plus FIFO bookkeeping; a pop on the last byte chains
    // straight into the next frame so back-to-back frames have no gap.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        frm_rd_d   = frm_rd_q;
        frm_data_d = frm_data_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) pop = 1'b1;
            end
            HDR: begin
                if (xfer) begin
                    state_d = DATA;
                    k_d     = '0;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (last) begin
                        if (level_q != '0) pop = 1'b1;
                        else               state_d = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            {frm_rd_d, frm_data_d} = mem_q[rd_ptr_q];
            k_d     = '0;
            state_d = (TAG_EN != 0) ? HDR : DATA;
        end
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        // A full-FIFO drop is judged on the registered level, so a same-cycle
        // pop does not rescue it.
        overflow_d = overflow_q | (wb_valid & ~wb_ready);
    end

    // State, pointer and frame registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            frm_rd_q   <= '0;
            frm_data_q <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            frm_rd_q   <= frm_rd_d;
            frm_data_q <= frm_data_d;
            k_q        <= k_d;
        end
    end

    // FIFO storage; contents are don't-care until the level covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wb_rd, wb_data};
    end

endmodule

// File: tb/tb_wb_trace_streamer.sv
// Bench for wb_trace_streamer: a default instance checked cycle by cycle
// against a queue-level model, plus a 32-bit big-endian untagged instance.
module tb_wb_trace_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [15:0] wb_data = '0;
    logic        out_ack = 1'b1;
    logic        wb_ready, out_strobe, out_sof, overflow;
    logic [7:0]  out_byte;
    logic [2:0]  fifo_level;

    logic        b_valid = 1'b0;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        b_ack = 1'b1;
    logic        b_ready, b_strobe, b_sof, b_ovf;
    logic [7:0]  b_byte;
    logic [2:0]  b_level;

    int n_chk = 0;
    int n_pass = 0;

    wb_trace_streamer dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ready(wb_ready), .out_byte(out_byte), .out_strobe(out_strobe), .out_sof(out_sof),
        .out_ack(out_ack), .fifo_level(fifo_level), .overflow(overflow)
    );

    wb_trace_streamer #(.DATA_W(32), .DEPTH(4), .TAG_EN(0), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst), .wb_valid(b_valid), .wb_rd(b_rd), .wb_data(b_data),
        .wb_ready(b_ready), .out_byte(b_byte), .out_strobe(b_strobe), .out_sof(b_sof),
        .out_ack(b_ack), .fifo_level(b_level), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    // Transfer monitor for the default instance (sampled mid low phase).
    int         cyc_cnt = 0;
    logic [7:0] obs_b[$];
    logic       obs_s[$];
    int         obs_c[$];
    always @(negedge clk) begin
        #2;
        cyc_cnt++;
        if (out_strobe && out_ack) begin
            obs_b.push_back(out_byte);
            obs_s.push_back(out_sof);
            obs_c.push_back(cyc_cnt);
        end
    end

    // Reference model: stored entries as a queue, the frame in flight as a
    // list of bytes with a remaining count.
    logic [20:0] mq[$];
    int          m_rem = 0;
    logic [7:0]  m_bytes[3];
    bit          m_ovf = 0;
    logic        e_strobe, e_sof, e_ready, e_ovf;
    logic [7:0]  e_byte;
    logic [2:0]  e_level;

    function automatic void model_advance();
        int sz;
        bit xf;
        logic [20:0] e;
        if (rst) begin
            mq.delete();
            m_rem = 0;
            m_ovf = 0;
            return;
        end
        sz = mq.size();
        xf = (m_rem > 0) && out_ack;
        if (wb_valid && sz >= 4) m_ovf = 1;
        if (xf) m_rem--;
        if (m_rem == 0 && sz > 0) begin
            e = mq.pop_front();
            m_bytes[0] = {3'b101, e[20:16]};
            m_bytes[1] = e[7:0];
            m_bytes[2] = e[15:8];
            m_rem = 3;
        end
        if (wb_valid && sz < 4) mq.push_back({wb_rd, wb_data});
    endfunction

    function automatic void model_outputs();
        e_strobe = (m_rem > 0);
        e_sof    = (m_rem == 3);
        e_byte   = (m_rem > 0) ? m_bytes[3 - m_rem] : 8'h00;
        e_level  = 3'(mq.size());
        e_ready  = (mq.size() < 4);
        e_ovf    = m_ovf;
    endfunction

    // One clock: model sees the inputs the DUT sampled, new inputs are
    // driven after the edge, and control returns at the falling edge.
    task automatic cyc(input logic v, input logic [4:0] rd, input logic [15:0] d,
                       input logic ack, input logic r);
        @(posedge clk);
        model_advance();
        #1;
        wb_valid = v; wb_rd = rd; wb_data = d; out_ack = ack; rst = r;
        model_outputs();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        n_chk++; if (out_strobe !== 1'b0) $display("FAIL reset_strobe: got %b exp 0", out_strobe); else n_pass++;
        n_chk++; if (out_byte !== 8'h00) $display("FAIL reset_byte: got %h exp 00", out_byte); else n_pass++;
        n_chk++; if (out_sof !== 1'b0) $display("FAIL reset_sof: got %b exp 0", out_sof); else n_pass++;
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d exp 0", fifo_level); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", overflow); else n_pass++;
        n_chk++; if (b_strobe !== 1'b0) $display("FAIL reset_be_strobe: got %b exp 0", b_strobe); else n_pass++;
        cyc(0, 0, 0, 1, 0);
        n_chk++; if (wb_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", wb_ready); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [7:0] eb[3];
        int first;
        eb[0] = 8'hA5; eb[1] = 8'hEF; eb[2] = 8'hBE;
        first = -1;
        obs_b.delete(); obs_s.delete(); obs_c.delete();
        cyc(1, 5'd5, 16'hBEEF, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (out_strobe === 1'b1 && first < 0) first = i;
            n_chk++;
            if ({out_strobe, out_sof, out_byte, fifo_level, wb_ready, overflow} !==
                {e_strobe, e_sof, e_byte, e_level, e_ready, e_ovf})
                $display("FAIL single_cyc%0d: got %h exp %h", i,
                         {out_strobe, out_sof, out_byte, fifo_level, wb_ready, overflow},
                         {e_strobe, e_sof, e_byte, e_level, e_ready, e_ovf});
            else n_pass++;
        end
        n_chk++; if (first !== 1) $display("FAIL single_latency: got %0d exp 1", first); else n_pass++;
        n_chk++; if (obs_b.size() !== 3) $display("FAIL single_len: got %0d exp 3", obs_b.size()); else n_pass++;
        for (int j = 0; j < 3 && j < obs_b.size(); j++) begin
            n_chk++;
            if (obs_b[j] !== eb[j] || obs_s[j] !== (j == 0) || obs_c[j] !== obs_c[0] + j)
                $display("FAIL single_byte%0d: got %h sof %b cyc %0d exp %h sof %b", j,
                         obs_b[j], obs_s[j], obs_c[j] - obs_c[0], eb[j], (j == 0));
            else n_pass++;
        end
    endtask

    task automatic test_big_endian();
        logic [7:0] eb[4];
        logic [7:0] gb[$];
        logic       gs[$];
        int first;
        eb[0] = 8'h12; eb[1] = 8'h34; eb[2] = 8'h56; eb[3] = 8'h78;
        first = -1;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h12345678;
        cyc(0, 0, 0, 1, 0);
        b_valid = 1'b0;
        n_chk++; if (b_level !== 3'd1 || b_strobe !== 1'b0)
            $display("FAIL be_push: got level %0d strobe %b exp 1 0", b_level, b_strobe); else n_pass++;
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            if (b_strobe === 1'b1) begin
                if (first < 0) first = i;
                gb.push_back(b_byte);
                gs.push_back(b_sof);
            end else begin
                n_chk++; if (b_byte !== 8'h00 || b_sof !== 1'b0)
                    $display("FAIL be_idle%0d: got byte %h sof %b exp 00 0", i, b_byte, b_sof); else n_pass++;
            end
        end
        n_chk++; if (first !== 1) $display("FAIL be_latency: got %0d exp 1", first); else n_pass++;
        n_chk++; if (gb.size() !== 4) $display("FAIL be_len: got %0d exp 4", gb.size()); else n_pass++;
        for (int j = 0; j < 4 && j < gb.size(); j++) begin
            n_chk++;
            if (gb[j] !== eb[j] || gs[j] !== (j == 0))
                $display("FAIL be_byte%0d: got %h sof %b exp %h sof %b", j, gb[j], gs[j], eb[j], (j == 0));
            else n_pass++;
        end
    endtask

    task automatic test_ack_hold();
        logic [7:0] eb[3];
        eb[0] = 8'hA9; eb[1] = 8'hA1; eb[2] = 8'hC3;
        obs_b.delete(); obs_s.delete(); obs_c.delete();
        cyc(1, 5'd9, 16'hC3A1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0);
            n_chk++;
            if ({out_strobe, out_sof, out_byte} !== {1'b1, 1'b0, 8'hA1})
                $display("FAIL hold%0d: got strobe %b sof %b byte %h exp 1 0 a1", i, out_strobe, out_sof, out_byte);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        n_chk++; if (obs_b.size() !== 3) $display("FAIL hold_len: got %0d exp 3", obs_b.size()); else n_pass++;
        for (int j = 0; j < 3 && j < obs_b.size(); j++) begin
            n_chk++;
            if (obs_b[j] !== eb[j] || obs_s[j] !== (j == 0))
                $display("FAIL hold_byte%0d: got %h sof %b exp %h sof %b", j, obs_b[j], obs_s[j], eb[j], (j == 0));
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d[6];
        logic [7:0]  eb[$];
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            d[i] = 16'($urandom);
            cyc(1, 5'(i + 1), d[i], 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        n_chk++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d exp 4", fifo_level); else n_pass++;
        n_chk++; if (wb_ready !== 1'b0) $display("FAIL ovf_ready: got %b exp 0", wb_ready); else n_pass++;
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", overflow); else n_pass++;
        n_chk++; if (out_strobe !== 1'b1 || out_byte !== 8'hA1)
            $display("FAIL ovf_inflight: got strobe %b byte %h exp 1 a1", out_strobe, out_byte); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            eb.push_back({3'b101, 5'(i + 1)});
            eb.push_back(d[i][7:0]);
            eb.push_back(d[i][15:8]);
        end
        obs_b.delete(); obs_s.delete(); obs_c.delete();
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 0);
        n_chk++; if (obs_b.size() !== 15) $display("FAIL ovf_len: got %0d exp 15", obs_b.size()); else n_pass++;
        for (int j = 0; j < 15 && j < obs_b.size(); j++) begin
            n_chk++;
            if (obs_b[j] !== eb[j] || obs_s[j] !== (j % 3 == 0) || obs_c[j] !== obs_c[0] + j)
                $display("FAIL ovf_byte%0d: got %h sof %b cyc %0d exp %h sof %b cyc %0d", j,
                         obs_b[j], obs_s[j], obs_c[j] - obs_c[0], eb[j], (j % 3 == 0), j);
            else n_pass++;
        end
        n_chk++; if (overflow !== 1'b1 || fifo_level !== 3'd0)
            $display("FAIL ovf_sticky: got ovf %b level %0d exp 1 0", overflow, fifo_level); else n_pass++;
    endtask

    task automatic test_stream_wrap();
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 65; i++) begin
            if (i < 45) cyc(1, 5'(i), 16'($urandom), 1, 0);
            else        cyc(0, 0, 0, 1, 0);
            n_chk++;
            if ({out_strobe, out_sof, out_byte, fifo_level, wb_ready, overflow} !==
                {e_strobe, e_sof, e_byte, e_level, e_ready, e_ovf})
                $display("FAIL wrap_cyc%0d: got %h exp %h", i,
                         {out_strobe, out_sof, out_byte, fifo_level, wb_ready, overflow},
                         {e_strobe, e_sof, e_byte, e_level, e_ready, e_ovf});
            else n_pass++;
        end
        n_chk++; if (overflow !== 1'b1) $display("FAIL wrap_sticky: got %b exp 1", overflow); else n_pass++;
    endtask

    task automatic test_random();
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom), ($urandom_range(0, 9) < 7), 0);
            n_chk++;
            if ({out_strobe, out_sof, out_byte, fifo_level, wb_ready, overflow} !==
                {e_strobe, e_sof, e_byte, e_level, e_ready, e_ovf})
                $display("FAIL rand_cyc%0d: got %h exp %h", i,
                         {out_strobe, out_sof, out_byte, fifo_level, wb_ready, overflow},
                         {e_strobe, e_sof, e_byte, e_level, e_ready, e_ovf});
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] d1;
        logic [7:0]  eb[3];
        eb[0] = 8'hA7; eb[1] = 8'h34; eb[2] = 8'h12;
        d1 = 16'($urandom);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 5'd1, d1, 1, 0);
        cyc(1, 5'd2, 16'($urandom), 1, 0);
        cyc(1, 5'd3, 16'($urandom), 1, 0);
        cyc(0, 0, 0, 1, 0);
        n_chk++; if ({out_strobe, out_sof, out_byte, fifo_level} !== {1'b1, 1'b0, d1[7:0], 3'd2})
            $display("FAIL mid_pre: got %h exp %h", {out_strobe, out_sof, out_byte, fifo_level},
                     {1'b1, 1'b0, d1[7:0], 3'd2}); else n_pass++;
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        n_chk++; if ({out_strobe, out_byte, fifo_level, overflow} !== 13'd0)
            $display("FAIL mid_post: got strobe %b byte %h level %0d ovf %b exp all 0",
                     out_strobe, out_byte, fifo_level, overflow); else n_pass++;
        obs_b.delete(); obs_s.delete(); obs_c.delete();
        cyc(1, 5'd7, 16'h1234, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1, 0);
            n_chk++;
            if ({out_strobe, out_sof, out_byte, fifo_level} !== {e_strobe, e_sof, e_byte, e_level})
                $display("FAIL mid_new_cyc%0d: got %h exp %h", i, {out_strobe, out_sof, out_byte, fifo_level},
                         {e_strobe, e_sof, e_byte, e_level});
            else n_pass++;
        end
        n_chk++; if (obs_b.size() !== 3) $display("FAIL mid_len: got %0d exp 3", obs_b.size()); else n_pass++;
        for (int j = 0; j < 3 && j < obs_b.size(); j++) begin
            n_chk++;
            if (obs_b[j] !== eb[j] || obs_s[j] !== (j == 0))
                $display("FAIL mid_byte%0d: got %h sof %b exp %h sof %b", j, obs_b[j], obs_s[j], eb[j], (j == 0));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_big_endian();
        test_ack_hold();
        test_overflow();
        test_stream_wrap();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
